// File: rtl/kb_send_pkg.sv
// kb_send_pkg: shared PS/2 transmitter types, command bytes and frame builder
// Provides the FSM state enum, common PS/2 command constants and make_frame(),
// which packs a byte into the 10-bit {stop, parity, data} transmit frame.
package kb_send_pkg;
   typedef enum logic [2:0] {IDLE, INHIBIT, DATA, ACK, WAIT_IDLE} state_t;
   localparam logic [7:0] KB_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] KB_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] KB_CMD_RESET    = 8'hFF;
   // odd parity: parity bit makes the total count of ones in data+parity odd
   function automatic logic [9:0] make_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction
endpackage

// File: rtl/kb_edge_sync.sv
// kb_edge_sync: two-flop synchronizer for the PS/2 lines plus clock falling-edge detect
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   kb_clk_i, kb_dat_i raw PS/2 pad levels (asynchronous)
//   clk_s, dat_s       synchronized line levels
//   clk_fall           one-cycle pulse when the synchronized clock goes 1 -> 0
module kb_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic kb_clk_i,
   input  logic kb_dat_i,
   output logic clk_s,
   output logic dat_s,
   output logic clk_fall
);
   logic [2:0] clk_h;
   logic [1:0] dat_h;
   // lines idle high, so reset to 1 to avoid a false edge after reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_h <= '1;
         dat_h <= '1;
      end else begin
         clk_h <= {clk_h[1:0], kb_clk_i};
         dat_h <= {dat_h[0], kb_dat_i};
      end
   end
   assign clk_s    = clk_h[1];
   assign dat_s    = dat_h[1];
   assign clk_fall = clk_h[2:1] == 2'b10;
endmodule

// File: rtl/kb_send.sv
// kb_send: PS/2 host-to-device transmitter for one command byte
// Ports:
//   clk_i, rst_i         system clock, synchronous active-high reset
//   kb_clk_i, kb_dat_i   PS/2 pad levels (asynchronous)
//   kb_clk_oe, kb_dat_oe 1 = pull the PS/2 clock/data line low
//   send, data           one-cycle request and byte, accepted while not busy
//   kb_busy              transfer in flight (gates the receiver)
//   done, err            end-of-transfer pulse; err flags NACK or timeout
module kb_send
   import kb_send_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int CNT_W          = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       kb_clk_i,
   input  logic       kb_dat_i,
   output logic       kb_clk_oe,
   output logic       kb_dat_oe,
   input  logic       send,
   input  logic [7:0] data,
   output logic       kb_busy,
   output logic       done,
   output logic       err
);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [9:0]       frame, frame_n;
   logic [3:0]       idx, idx_n;
   logic             nack, nack_n;
   logic             clk_oe_n, dat_oe_n, done_n, err_n;
   logic             clk_s, dat_s, clk_fall;
   kb_edge_sync u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .kb_clk_i (kb_clk_i),
      .kb_dat_i (kb_dat_i),
      .clk_s    (clk_s),
      .dat_s    (dat_s),
      .clk_fall (clk_fall)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         frame     <= '0;
         idx       <= '0;
         nack      <= 1'b0;
         kb_clk_oe <= 1'b0;
         kb_dat_oe <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         frame     <= frame_n;
         idx       <= idx_n;
         nack      <= nack_n;
         kb_clk_oe <= clk_oe_n;
         kb_dat_oe <= dat_oe_n;
         done      <= done_n;
         err       <= err_n;
      end
   end
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      frame_n  = frame;
      idx_n    = idx;
      nack_n   = nack;
      clk_oe_n = kb_clk_oe;
      dat_oe_n = kb_dat_oe;
      done_n   = 1'b0;
      err_n    = 1'b0;
      case (state)
         IDLE: if (send) begin
            frame_n  = make_frame(data);
            clk_oe_n = 1'b1;
            dat_oe_n = 1'b0;
            cnt_n    = '0;
            nack_n   = 1'b0;
            state_n  = INHIBIT;
         end
         // data already low marks the start-bit cycle: release the clock next
         INHIBIT: if (kb_dat_oe) begin
            clk_oe_n = 1'b0;
            idx_n    = '0;
            state_n  = DATA;
         end else if (cnt == INH_LAST) begin
            dat_oe_n = 1'b1;
            cnt_n    = '0;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         default: begin
            cnt_n = clk_fall ? '0 : cnt + 1'b1;
            if (state == WAIT_IDLE && clk_s && dat_s) begin
               done_n  = 1'b1;
               err_n   = nack;
               state_n = IDLE;
            end else if (clk_fall) begin
               if (state == DATA) begin
                  dat_oe_n = ~frame[0];
                  frame_n  = frame >> 1;
                  idx_n    = idx + 4'd1;
                  state_n  = idx == 4'd9 ? ACK : DATA;
               end else if (state == ACK) begin
                  nack_n  = dat_s;
                  state_n = WAIT_IDLE;
               end
            end else if (cnt == TO_LAST) begin
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b0;
               done_n   = 1'b1;
               err_n    = 1'b1;
               state_n  = IDLE;
            end
         end
      endcase
   end
   assign kb_busy = state != IDLE;
endmodule
